// File: rtl/ram_lsu_pkg.sv
// ram_lsu_pkg: shared types, lane constant and lane extract/merge helpers for the load/store unit
package ram_lsu_pkg;
  localparam int LANE_W = 8;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_X} size_e;
  typedef enum logic [2:0] {ST_IDLE, ST_RD_ISSUE, ST_RD_WAIT, ST_WR, ST_RESP} state_e;
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] lane, input size_e sz, input logic uns);
    logic [7:0] b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: LANE_W];
    h = w[{lane[1], 4'b0000} +: 2*LANE_W];
    return (sz == SZ_B) ? {{24{b[7] & ~uns}}, b} : (sz == SZ_H) ? {{16{h[15] & ~uns}}, h} : w;
  endfunction
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] lane, input size_e sz, input logic [31:0] wd);
    logic [31:0] m;
    m = w;
    if (sz == SZ_B) m[{lane, 3'b000} +: LANE_W] = wd[LANE_W-1:0];
    else if (sz == SZ_H) m[{lane[1], 4'b0000} +: 2*LANE_W] = wd[2*LANE_W-1:0];
    else m = wd;
    return m;
  endfunction
endpackage

// File: rtl/ram_lsu_lane_align.sv
// lsu_lane_align: combinational lane extraction for loads and byte/half merge for sub-word stores
import ram_lsu_pkg::*;
module lsu_lane_align (
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);
  assign load_o  = load_extract(word_i, lane_i, size_i, unsigned_i);
  assign merge_o = store_merge(word_i, lane_i, size_i, wdata_i);
endmodule

// File: rtl/ram_lsu.sv
// ram_lsu: byte-addressed load/store initiator for a word-wide single-port RAM; LSU_ALIGN_CHECK_EN enables alignment/size/range errors
import ram_lsu_pkg::*;
module ram_lsu #(
  parameter int          ADDR_W    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ram_wen,
  output logic              ram_ren,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  state_e state_q, state_d;
  size_e size_q, size_d;
  logic we_q, we_d, uns_q, uns_d, err_q, err_d, bad, unused_off;
  logic [1:0] lane_q, lane_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, off, load_w, merge_w;
  assign off = req_addr - BASE_ADDR;
  assign unused_off = ^{off[31:ADDR_W+2], off[1:0]};
`ifdef LSU_ALIGN_CHECK_EN
  assign bad = (req_size == SZ_X) || (req_size == SZ_H && req_addr[0]) ||
               (req_size == SZ_W && |req_addr[1:0]) || |off[31:ADDR_W+2];
`else
  assign bad = 1'b0;
`endif
  lsu_lane_align u_align (
    .word_i(ram_rdata), .lane_i(lane_q), .size_i(size_q), .unsigned_i(uns_q),
    .wdata_i(wdata_q), .load_o(load_w), .merge_o(merge_w)
  );
  // next state: latch on accept, extract/merge on the RAM read return
  always_comb begin
    state_d = state_q;
    we_d = we_q;
    size_d = size_q;
    uns_d = uns_q;
    lane_d = lane_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d = err_q;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        we_d = req_we;
        size_d = size_e'(req_size);
        uns_d = req_unsigned;
        lane_d = req_addr[1:0];
        addr_d = off[ADDR_W+1:2];
        wdata_d = req_wdata;
        rdata_d = '0;
        err_d = bad;
        state_d = bad ? ST_RESP : (req_we && req_size[1]) ? ST_WR : ST_RD_ISSUE;
      end
      ST_RD_ISSUE: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        rdata_d = we_q ? '0 : load_w;
        wdata_d = merge_w;
        state_d = we_q ? ST_WR : ST_RESP;
      end
      ST_WR: state_d = ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end
  // state and request registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q <= 1'b0;
      size_q <= SZ_B;
      uns_q <= 1'b0;
      lane_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      size_q <= size_d;
      uns_q <= uns_d;
      lane_q <= lane_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  assign req_ready = state_q == ST_IDLE;
  assign rsp_valid = state_q == ST_RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign ram_ren   = rst_n && state_q == ST_RD_ISSUE;
  assign ram_wen   = rst_n && state_q == ST_WR;
  assign ram_waddr = addr_q;
  assign ram_raddr = addr_q;
  assign ram_wdata = ram_wen ? wdata_q : '0;
endmodule

// File: tb/tb_ram_lsu.sv
// tb_ram_lsu: directed checks of ram_lsu against a byte-level memory model with per-cycle output comparison
module tb_ram_lsu;
  localparam int ADDR_W = 14;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int BYTES = 4 * DEPTH;
  localparam logic [31:0] BASE = 32'h0;
  typedef struct {int c; logic [31:0] rd; logic err;} exp_t;
  logic clk = 0, rst_n = 0, req_valid = 0, req_we = 0, req_unsigned = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, rsp_rdata, ram_wdata, ram_rdata;
  logic req_ready, rsp_valid, rsp_err, ram_wen, ram_ren;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [31:0] ram [0:DEPTH-1];
  logic [7:0] mem_b [0:BYTES-1];
  exp_t q[$];
  int cyc = 0, tests = 0, fails = 0, n_ren = 0, n_wen = 0;
  bit checking = 0;
  logic [31:0] exp_waddr = 0, exp_wword = 0;

  ram_lsu #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .ram_wen(ram_wen), .ram_ren(ram_ren),
    .ram_waddr(ram_waddr), .ram_raddr(ram_raddr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (ram_wen) ram[ram_waddr] <= ram_wdata;
    if (ram_ren) ram_rdata <= ram[ram_raddr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                       input logic [31:0] wd, output int lat, output logic [31:0] rd, output bit err,
                       output int nr, output int nw);
    logic [31:0] off, a, v;
    logic [1:0] s;
    int n;
    off = addr - BASE;
    s = sz;
    rd = 0;
`ifdef LSU_ALIGN_CHECK_EN
    err = (sz == 3) || (sz == 1 && addr[0]) || (sz == 2 && addr[1:0] != 0) || (off >= BYTES);
`else
    err = 0;
    if (s == 3) s = 2;
`endif
    n = (s == 0) ? 1 : (s == 1) ? 2 : 4;
    a = (off & (BYTES - 1)) & ~(n - 1);
    exp_waddr = a >> 2;
    if (err) begin
      lat = 1; nr = 0; nw = 0;
    end else if (!we) begin
      v = 0;
      for (int i = 0; i < n; i++) v |= 32'(mem_b[a + i]) << (8 * i);
      if (!uns && n < 4 && v[8 * n - 1]) v |= 32'hFFFF_FFFF << (8 * n);
      rd = v; lat = 3; nr = 1; nw = 0;
    end else begin
      for (int i = 0; i < n; i++) mem_b[a + i] = wd[8 * i +: 8];
      a = a & ~32'd3;
      exp_wword = {mem_b[a + 3], mem_b[a + 2], mem_b[a + 1], mem_b[a]};
      lat = (n == 4) ? 2 : 4; nr = (n == 4) ? 0 : 1; nw = 1;
    end
  endtask

  task automatic do_req(input string nm, input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] lit);
    int lat, nr, nw, t;
    logic [31:0] rd;
    bit err;
    exp_t e;
    @(negedge clk);
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    if (!req_ready) chk({nm, "_ready_timeout"}, 32'(req_ready), 1);
    model(we, sz, uns, addr, wd, lat, rd, err, nr, nw);
    chk({nm, "_model"}, (we && !err) ? exp_wword : rd, lit);
    e.c = cyc + lat; e.rd = rd; e.err = err;
    q.push_back(e);
    n_ren = 0; n_wen = 0;
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 0;
    repeat (lat) @(negedge clk);
    chk({nm, "_n_ren"}, n_ren, nr);
    chk({nm, "_n_wen"}, n_wen, nw);
  endtask

  // per-cycle comparison of DUT outputs against the scheduled model responses
  always @(negedge clk) begin
    #1;
    if (checking) begin
      if (q.size() > 0 && q[0].c < cyc) void'(q.pop_front());
      if (q.size() > 0 && q[0].c == cyc) begin
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_rdata", rsp_rdata, q[0].rd);
        chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
        void'(q.pop_front());
      end else chk("rsp_valid_idle", 32'(rsp_valid), 0);
      chk("raddr_eq_waddr", 32'(ram_raddr), 32'(ram_waddr));
      if (ram_wen) begin
        chk("ram_waddr", 32'(ram_waddr), exp_waddr);
        chk("ram_wdata", ram_wdata, exp_wword);
      end else chk("ram_wdata_zero", ram_wdata, 0);
      n_ren += 32'(ram_ren);
      n_wen += 32'(ram_wen);
    end
  end

  initial begin
    int c, lat, nr, nw;
    logic [31:0] rd;
    bit err;
    exp_t e;
    for (int i = 0; i < DEPTH; i++) ram[i] = 0;
    for (int i = 0; i < BYTES; i++) mem_b[i] = 0;
    ram_rdata = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", 32'(rsp_err), 0);
    chk("rst_wen_ren", {30'd0, ram_wen, ram_ren}, 0);
    chk("rst_waddr", 32'(ram_waddr), 0);
    checking = 1;

    do_req("sw_10", 1, 2, 0, 32'h10, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_req("lb_13", 0, 0, 0, 32'h13, 0, 32'hFFFF_FFDE);
    do_req("lbu_13", 0, 0, 1, 32'h13, 0, 32'h0000_00DE);
    do_req("lh_10", 0, 1, 0, 32'h10, 0, 32'hFFFF_BEEF);
    do_req("sh_12", 1, 1, 0, 32'h12, 32'hAAAA_1234, 32'h1234_BEEF);
    do_req("lw_10", 0, 2, 0, 32'h10, 0, 32'h1234_BEEF);
`ifdef LSU_ALIGN_CHECK_EN
    do_req("lh_11_err", 0, 1, 0, 32'h11, 0, 32'h0);
    do_req("lw_40000_err", 0, 2, 0, 32'h4_0000, 0, 32'h0);
    do_req("lx_10_err", 0, 3, 0, 32'h10, 0, 32'h0);
    do_req("sw_12_err", 1, 2, 0, 32'h12, 32'h5555_5555, 32'h0);
`else
    do_req("lh_11_align", 0, 1, 0, 32'h11, 0, 32'hFFFF_BEEF);
    do_req("lw_40000_wrap", 0, 2, 0, 32'h4_0000, 0, 32'h0);
    do_req("lx_10_word", 0, 3, 0, 32'h10, 0, 32'h1234_BEEF);
`endif
    do_req("sb_11", 1, 0, 0, 32'h11, 32'hFFFF_FFA5, 32'h1234_A5EF);
    do_req("lb_11", 0, 0, 0, 32'h11, 0, 32'hFFFF_FFA5);
    do_req("lhu_12", 0, 1, 1, 32'h12, 0, 32'h0000_1234);
    do_req("sh_20", 1, 1, 0, 32'h20, 32'h0000_8001, 32'h0000_8001);
    do_req("lh_20", 0, 1, 0, 32'h20, 0, 32'hFFFF_8001);

    // reset asserted during the WR cycle of a byte store aborts it
    @(negedge clk);
    req_valid = 1; req_we = 1; req_size = 0; req_unsigned = 0; req_addr = 32'h10; req_wdata = 32'h77;
    @(negedge clk);
    req_valid = 0;
    repeat (2) @(negedge clk);
    chk("abort_in_wr", 32'(ram_wen), 1);
    rst_n = 0;
    #1;
    chk("abort_wen", 32'(ram_wen), 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("abort_ready", 32'(req_ready), 1);
    do_req("lw_after_abort", 0, 2, 0, 32'h10, 0, 32'h1234_A5EF);

    // two loads with req_valid held high
    @(negedge clk);
    c = cyc;
    model(0, 2, 0, 32'h10, 0, lat, rd, err, nr, nw);
    e.c = c + lat; e.rd = rd; e.err = err;
    q.push_back(e);
    req_valid = 1; req_we = 0; req_size = 2; req_addr = 32'h10;
    @(negedge clk);
    chk("b2b_ready_n1", 32'(req_ready), 0);
    req_addr = 32'h20;
    model(0, 2, 0, 32'h20, 0, lat, rd, err, nr, nw);
    @(negedge clk);
    chk("b2b_ready_n2", 32'(req_ready), 0);
    @(negedge clk);
    chk("b2b_ready_n3", 32'(req_ready), 0);
    @(negedge clk);
    chk("b2b_ready_after", 32'(req_ready), 1);
    e.c = cyc + lat; e.rd = rd; e.err = err;
    q.push_back(e);
    @(negedge clk);
    chk("b2b_second_accepted", 32'(req_ready), 0);
    req_valid = 0;
    repeat (4) @(negedge clk);
    chk("pending_responses", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
